// File: rtl/esfa_cell_pipe.sv
// esfa_cell_pipe -- one element of the ESFA sparse-array cell array.
//
// Stores a single sparse-array element (occupied, code, index, value, rank)
// and executes one operation per accepted request behind valid/ready flow
// control. A request is latched in IDLE, executed in EXEC against the stored
// fields (result taken from the pre-update fields, write committed on the
// same edge), optionally delayed through STAGE, and presented in RESP until
// the consumer takes it. Only one request is ever outstanding.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   req_valid / req_ready     request handshake (ready only while IDLE)
//   req_op, req_wr            opcode and write-commit enable
//   req_handle                array handle compared against the stored code
//   req_index, req_value      element index (range low) and element value
//   req_meta                  rank on CLAIM, range high on RANGE
//   rsp_valid / rsp_ready     response handshake
//   rsp_bool, rsp_value       operation results
//   rsp_context               stored rank at execution time
//   cell_busy, cell_occ       FSM not idle, element occupied
module esfa_cell_pipe #(
   parameter int KEY_W   = 8,
   parameter int DATA_W  = 8,
   parameter int RANK_W  = 8,
   parameter int OUT_REG = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic              req_wr,
   input  logic [KEY_W-1:0]  req_handle,
   input  logic [DATA_W-1:0] req_index,
   input  logic [DATA_W-1:0] req_value,
   input  logic [DATA_W-1:0] req_meta,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_bool,
   output logic [DATA_W-1:0] rsp_value,
   output logic [RANK_W-1:0] rsp_context,
   output logic              cell_busy,
   output logic              cell_occ
);

   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_STAGE, ST_RESP} state_e;

   typedef enum logic [2:0] {
      OP_NOP, OP_LOOKUP, OP_UPDATE, OP_CLAIM,
      OP_DELETE, OP_RANGE, OP_RERANK, OP_FREE
   } op_e;

   state_e              state_q, state_d;

   // Latched request
   op_e                 op_q, op_d;
   logic                wr_q, wr_d;
   logic [KEY_W-1:0]    handle_q, handle_d;
   logic [DATA_W-1:0]   r_index_q, r_index_d;
   logic [DATA_W-1:0]   r_value_q, r_value_d;
   logic [DATA_W-1:0]   meta_q, meta_d;

   // Stored element
   logic                occ_q, occ_d;
   logic [KEY_W-1:0]    code_q, code_d;
   logic [DATA_W-1:0]   index_q, index_d;
   logic [DATA_W-1:0]   value_q, value_d;
   logic [RANK_W-1:0]   rank_q, rank_d;

   // Optional output stage and response registers
   logic                stg_bool_q, stg_bool_d;
   logic [DATA_W-1:0]   stg_value_q, stg_value_d;
   logic [RANK_W-1:0]   stg_ctx_q, stg_ctx_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_bool_q, rsp_bool_d;
   logic [DATA_W-1:0]   rsp_value_q, rsp_value_d;
   logic [RANK_W-1:0]   rsp_ctx_q, rsp_ctx_d;

   logic                own, hit, exec_wr;
   logic                res_bool;
   logic [DATA_W-1:0]   res_value;

   assign own     = occ_q && (code_q == handle_q);
   assign hit     = own && (index_q == r_index_q);
   assign exec_wr = (state_q == ST_EXEC) && wr_q;

   always_comb begin
      // NOTE: every signal gets a default before any branch so no path
      // leaves it unassigned; otherwise synthesis infers a latch.
      state_d     = state_q;
      op_d        = op_q;
      wr_d        = wr_q;
      handle_d    = handle_q;
      r_index_d   = r_index_q;
      r_value_d   = r_value_q;
      meta_d      = meta_q;
      occ_d       = occ_q;
      code_d      = code_q;
      index_d     = index_q;
      value_d     = value_q;
      rank_d      = rank_q;
      stg_bool_d  = stg_bool_q;
      stg_value_d = stg_value_q;
      stg_ctx_d   = stg_ctx_q;
      rsp_valid_d = rsp_valid_q;
      rsp_bool_d  = rsp_bool_q;
      rsp_value_d = rsp_value_q;
      rsp_ctx_d   = rsp_ctx_q;
      res_bool    = 1'b0;
      res_value   = '0;

      // Results always come from the pre-update fields; the write side only
      // takes effect while executing with req_wr set.
      unique case (op_q)
         OP_NOP: ;
         OP_LOOKUP: begin
            res_bool  = hit;
            res_value = hit ? value_q : '0;
         end
         OP_UPDATE: begin
            res_bool  = hit;
            res_value = value_q;
            if (exec_wr && hit) value_d = r_value_q;
         end
         OP_CLAIM: begin
            // A matching code does not make an occupied cell claimable.
            res_bool = !occ_q;
            if (exec_wr && !occ_q) begin
               occ_d   = 1'b1;
               code_d  = handle_q;
               index_d = r_index_q;
               value_d = r_value_q;
               rank_d  = RANK_W'(meta_q);
            end
         end
         OP_DELETE: begin
            res_bool  = own;
            res_value = value_q;
            if (exec_wr && own) occ_d = 1'b0;
         end
         OP_RANGE: begin
            res_bool  = own && (r_index_q <= index_q) && (index_q <= meta_q);
            res_value = index_q;
         end
         OP_RERANK: begin
            res_bool = own;
            if (exec_wr && own && (rank_q != '1)) rank_d = rank_q + 1'b1;
         end
         OP_FREE: res_bool = !occ_q;
      endcase

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               op_d      = op_e'(req_op);
               wr_d      = req_wr;
               handle_d  = req_handle;
               r_index_d = req_index;
               r_value_d = req_value;
               meta_d    = req_meta;
               state_d   = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (OUT_REG != 0) begin
               stg_bool_d  = res_bool;
               stg_value_d = res_value;
               stg_ctx_d   = rank_q;
               state_d     = ST_STAGE;
            end else begin
               rsp_bool_d  = res_bool;
               rsp_value_d = res_value;
               rsp_ctx_d   = rank_q;
               state_d     = ST_RESP;
            end
         end
         ST_STAGE: begin
            rsp_bool_d  = stg_bool_q;
            rsp_value_d = stg_value_q;
            rsp_ctx_d   = stg_ctx_q;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            // rsp_valid rises one cycle into RESP; rsp_ready is ignored
            // until then, and the handshake returns the cell to IDLE.
            if (!rsp_valid_q) begin
               rsp_valid_d = 1'b1;
            end else if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      if (rst) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_NOP;
         wr_q        <= 1'b0;
         handle_q    <= '0;
         r_index_q   <= '0;
         r_value_q   <= '0;
         meta_q      <= '0;
         occ_q       <= 1'b0;
         code_q      <= '0;
         index_q     <= '0;
         value_q     <= '0;
         rank_q      <= '0;
         stg_bool_q  <= 1'b0;
         stg_value_q <= '0;
         stg_ctx_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_bool_q  <= 1'b0;
         rsp_value_q <= '0;
         rsp_ctx_q   <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         wr_q        <= wr_d;
         handle_q    <= handle_d;
         r_index_q   <= r_index_d;
         r_value_q   <= r_value_d;
         meta_q      <= meta_d;
         occ_q       <= occ_d;
         code_q      <= code_d;
         index_q     <= index_d;
         value_q     <= value_d;
         rank_q      <= rank_d;
         stg_bool_q  <= stg_bool_d;
         stg_value_q <= stg_value_d;
         stg_ctx_q   <= stg_ctx_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_bool_q  <= rsp_bool_d;
         rsp_value_q <= rsp_value_d;
         rsp_ctx_q   <= rsp_ctx_d;
      end
   end

   assign req_ready   = (state_q == ST_IDLE);
   assign cell_busy   = (state_q != ST_IDLE);
   assign cell_occ    = occ_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_bool    = rsp_bool_q;
   assign rsp_value   = rsp_value_q;
   assign rsp_context = rsp_ctx_q;

endmodule
